// File: rtl/isi_pkg.sv
// Shared constants, types and helpers for the spike inter-spike-interval encoder.
package isi_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef logic [CNT_W_DEF-1:0] isi_t;

    // All-ones value of a counter of the given width, used as the saturation ceiling.
    function automatic logic [63:0] isi_sat(input int unsigned width);
        if (width >= 32'd64) begin
            isi_sat = {64{1'b1}};
        end else begin
            isi_sat = (64'd1 << width) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/isi_fifo.sv
// Small synchronous FIFO with a registered head word; the level counter disambiguates full/empty.
module isi_fifo
    import isi_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_next_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_next_s;
    logic             valid_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s       = (level_r == DEPTH_L);
    assign empty_s      = (level_r == {LVL_W{1'b0}});
    assign do_pop_s     = pop & ~empty_s;
    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign do_push_s    = push & (~full_s | do_pop_s);
    assign rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);

    // Next occupancy from accepted push/pop.
    always_comb begin
        level_next_s = level_r;
        case ({do_push_s, do_pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Next head word: the incoming word when it lands in an empty slot, else the successor entry.
    always_comb begin
        head_next_s = head_r;
        if (level_next_s == {LVL_W{1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (empty_s && do_push_s) begin
            head_next_s = din;
        end else if (do_pop_s) begin
            if ((level_r == LVL_W'(1)) && do_push_s) begin
                head_next_s = din;
            end else begin
                head_next_s = mem_r[rd_ptr_inc_s];
            end
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, level and registered head/valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            level_r <= level_next_s;
            head_r  <= head_next_s;
            valid_r <= (level_next_s != {LVL_W{1'b0}});
        end
    end

    assign dout  = head_r;
    assign valid = valid_r;
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

endmodule

// File: rtl/spike_isi_encoder.sv
// Measures cycles between rising spike edges and queues each interval for a valid/ready consumer.
module spike_isi_encoder
    import isi_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          spike,
    output logic [CNT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop_flag,
    output logic [7:0]                    spike_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(isi_sat(CNT_W));

    logic             spike_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             armed_r;
    logic [7:0]       spike_cnt_r;
    logic             drop_r;
    logic             event_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;

    assign event_s = en & spike & ~spike_q_r;
    assign push_s  = event_s & armed_r;
    assign pop_s   = out_ready & ~empty_s;

    // Previous spike sample for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_q_r <= 1'b0;
        end else begin
            spike_q_r <= spike;
        end
    end

    // Interval counter and arm flag; the counter restarts at 1 so a push carries the full gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            armed_r <= 1'b0;
        end else if (!en) begin
            cnt_r   <= {CNT_W{1'b0}};
            armed_r <= 1'b0;
        end else if (event_s) begin
            cnt_r   <= CNT_W'(1);
            armed_r <= 1'b1;
        end else if (cnt_r != CNT_SAT) begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // Event counter and sticky overflow indicator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_cnt_r <= 8'd0;
            drop_r      <= 1'b0;
        end else begin
            if (event_s) begin
                spike_cnt_r <= spike_cnt_r + 8'd1;
            end
            if (push_s && full_s && !pop_s) begin
                drop_r <= 1'b1;
            end
        end
    end

    isi_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (cnt_r),
        .dout  (out_data),
        .valid (out_valid),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level)
    );

    assign drop_flag = drop_r;
    assign spike_cnt = spike_cnt_r;

endmodule

// File: tb/tb_spike_isi_encoder.sv
// Directed self-checking bench for spike_isi_encoder (16-bit default instance plus an 8-bit instance).
module tb_spike_isi_encoder;

    logic        clk;
    logic        reset;
    logic        en;
    logic        spike;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  fifo_level;
    logic        drop_flag;
    logic [7:0]  spike_cnt;

    logic        en8;
    logic        spike8;
    logic        out_ready8;
    logic [7:0]  out_data8;
    logic        out_valid8;
    logic [2:0]  fifo_level8;
    logic        drop_flag8;
    logic [7:0]  spike_cnt8;

    int checks = 0;
    int errors = 0;

    spike_isi_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .spike      (spike),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .drop_flag  (drop_flag),
        .spike_cnt  (spike_cnt)
    );

    spike_isi_encoder #(.CNT_W(8), .FIFO_DEPTH(4)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .en         (en8),
        .spike      (spike8),
        .out_data   (out_data8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .fifo_level (fifo_level8),
        .drop_flag  (drop_flag8),
        .spike_cnt  (spike_cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Spike is sampled high at exactly one rising edge.
    task automatic pulse();
        spike = 1'b1;
        step(1);
        spike = 1'b0;
    endtask

    task automatic pulse8();
        spike8 = 1'b1;
        step(1);
        spike8 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; spike = 1'b0; out_ready = 1'b0;
        en8 = 1'b0; spike8 = 1'b0; out_ready8 = 1'b0;

        // 1. reset state
        step(3);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_drop", {31'd0, drop_flag}, 32'd0);
        chk("rst_spike_cnt", {24'd0, spike_cnt}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        reset = 1'b0;
        step(1);
        chk("post_rst_level", {29'd0, fifo_level}, 32'd0);

        // 2. intervals 15 and 20
        en = 1'b1; out_ready = 1'b1;
        pulse();
        chk("t2_arm_level", {29'd0, fifo_level}, 32'd0);
        chk("t2_arm_cnt", {24'd0, spike_cnt}, 32'd1);
        step(14);
        pulse();
        chk("t2_valid1", {31'd0, out_valid}, 32'd1);
        chk("t2_word15", {16'd0, out_data}, 32'd15);
        step(19);
        pulse();
        chk("t2_word20", {16'd0, out_data}, 32'd20);
        chk("t2_spike_cnt", {24'd0, spike_cnt}, 32'd3);

        // 3. held spike counts once
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        spike = 1'b1;
        step(6);
        spike = 1'b0;
        chk("t3_hold_level", {29'd0, fifo_level}, 32'd0);
        chk("t3_hold_cnt", {24'd0, spike_cnt}, 32'd1);
        step(4);
        pulse();
        chk("t3_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_word10", {16'd0, out_data}, 32'd10);
        chk("t3_spike_cnt", {24'd0, spike_cnt}, 32'd2);

        // 4. fill, overflow, then push+pop while full
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        pulse();
        step(2); pulse();
        step(3); pulse();
        step(4); pulse();
        step(5); pulse();
        chk("t4_full_level", {29'd0, fifo_level}, 32'd4);
        chk("t4_no_drop_yet", {31'd0, drop_flag}, 32'd0);
        step(6); pulse();
        chk("t4_drop", {31'd0, drop_flag}, 32'd1);
        chk("t4_level_after_drop", {29'd0, fifo_level}, 32'd4);
        chk("t4_head_held", {16'd0, out_data}, 32'd3);
        chk("t4_spike_cnt", {24'd0, spike_cnt}, 32'd6);
        step(7);
        out_ready = 1'b1;
        pulse();
        chk("t4_pushpop_level", {29'd0, fifo_level}, 32'd4);
        chk("t4_head4", {16'd0, out_data}, 32'd4);
        step(1);
        chk("t4_head5", {16'd0, out_data}, 32'd5);
        step(1);
        chk("t4_head6", {16'd0, out_data}, 32'd6);
        step(1);
        chk("t4_head8", {16'd0, out_data}, 32'd8);
        step(1);
        chk("t4_drained_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_drained_level", {29'd0, fifo_level}, 32'd0);
        chk("t4_drop_sticky", {31'd0, drop_flag}, 32'd1);

        // 5. saturation with 8-bit counter, en gap disarms
        do_reset();
        en8 = 1'b1; out_ready8 = 1'b0;
        pulse8();
        step(299);
        pulse8();
        chk("t5_level8", {29'd0, fifo_level8}, 32'd1);
        chk("t5_sat255", {24'd0, out_data8}, 32'd255);
        step(100);
        en8 = 1'b0;
        step(1);
        en8 = 1'b1;
        step(100);
        pulse8();
        chk("t5_rearm_no_push", {29'd0, fifo_level8}, 32'd1);
        chk("t5_spike_cnt8", {24'd0, spike_cnt8}, 32'd3);
        step(4);
        pulse8();
        chk("t5_armed_push", {29'd0, fifo_level8}, 32'd2);
        chk("t5_head_kept", {24'd0, out_data8}, 32'd255);

        // 6. asynchronous reset mid-operation
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        pulse();
        step(4); pulse();
        step(5); pulse();
        chk("t6_level2", {29'd0, fifo_level}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_async_level", {29'd0, fifo_level}, 32'd0);
        #1;
        reset = 1'b0;
        step(1);
        pulse();
        chk("t6_first_no_push", {29'd0, fifo_level}, 32'd0);
        step(2);
        pulse();
        chk("t6_second_push", {29'd0, fifo_level}, 32'd1);
        chk("t6_word3", {16'd0, out_data}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
